// File: rtl/stream_eq_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_eq_monitor_if
// Purpose  : Handshake/status bundle between two streaming DUTs and the
//            stream_eq_monitor checker. Optional tlast: STREAM_EQ_TLAST_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface stream_eq_monitor_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
);
`ifdef STREAM_EQ_TLAST_EN
   logic              a_tlast;
   logic              b_tlast;
`endif
   logic              start;
   logic              a_complete;
   logic              b_complete;
   logic [DATA_W-1:0] a_tdata;
   logic [DATA_W-1:0] b_tdata;
   logic              a_tvalid;
   logic              b_tvalid;
   logic              a_tready;
   logic              b_tready;
   logic              a_step;
   logic              b_step;
   logic              busy;
   logic              done;
   logic              pass;
   logic              mismatch;
   logic              timeout;
   logic [CNT_W-1:0]  mismatch_idx;
   logic [CNT_W-1:0]  match_cnt;

   modport master (
`ifdef STREAM_EQ_TLAST_EN
      output a_tlast, b_tlast,
`endif
      output start, a_complete, b_complete, a_tdata, b_tdata, a_tvalid, b_tvalid,
      input  a_tready, b_tready, a_step, b_step, busy, done, pass, mismatch,
      input  timeout, mismatch_idx, match_cnt
   );

   modport slave (
`ifdef STREAM_EQ_TLAST_EN
      input  a_tlast, b_tlast,
`endif
      input  start, a_complete, b_complete, a_tdata, b_tdata, a_tvalid, b_tvalid,
      output a_tready, b_tready, a_step, b_step, busy, done, pass, mismatch,
      output timeout, mismatch_idx, match_cnt
   );
endinterface
`default_nettype wire

// File: rtl/stream_eq_monitor.sv
`default_nettype none
// ============================================================================
// Module   : stream_eq_monitor
// Purpose  : Latency-tolerant in-order equivalence checker for two streaming
//            designs. Optional tlast support: define STREAM_EQ_TLAST_EN.
// Revision : 1.0 - initial release
// ============================================================================
module stream_eq_monitor #(
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 4,
   parameter int WAIT_CYCLES = 5,
   parameter int CNT_W       = 16,
   parameter int TIMEOUT     = 4096
) (
   input  wire logic          clk,
   input  wire logic          rst,
   stream_eq_monitor_if.slave mon
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
`ifdef STREAM_EQ_TLAST_EN
   localparam int FW = DATA_W + 1;
`else
   localparam int FW = DATA_W;
`endif
   localparam int WW = $clog2(WAIT_CYCLES + 2);

   localparam logic [WW-1:0]    c_WAIT_MAX = WW'(WAIT_CYCLES);
   localparam logic [WW-1:0]    c_WAIT_SAT = WW'(WAIT_CYCLES + 1);
   localparam logic [CNT_W-1:0] c_TO_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_DRAIN = 3'd2,
      S_PASS  = 3'd3,
      S_FAIL  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [PW-1:0]    wr_q [2];
   logic [PW-1:0]    wr_d [2];
   logic [PW-1:0]    rd_q [2];
   logic [PW-1:0]    rd_d [2];
   logic [WW-1:0]    w_q  [2];
   logic [WW-1:0]    w_d  [2];
   logic [CNT_W-1:0] cycle_q, cycle_d;
   logic [CNT_W-1:0] match_q, match_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic             mis_q, mis_d;
   logic             to_q, to_d;
   logic [FW-1:0]    mem_q [2][DEPTH];

   logic [FW-1:0]    tok  [2];
   logic [FW-1:0]    head [2];
   logic [1:0]       complete, tvalid, step, tready, full, empty, push;
   logic             busy, pop_both, heads_eq, go_drain;

   // Index 0 is side A, index 1 is side B throughout.
`ifdef STREAM_EQ_TLAST_EN
   assign tok[0] = {mon.a_tlast, mon.a_tdata};
   assign tok[1] = {mon.b_tlast, mon.b_tdata};
`else
   assign tok[0] = mon.a_tdata;
   assign tok[1] = mon.b_tdata;
`endif
   assign complete = {mon.b_complete, mon.a_complete};
   assign tvalid   = {mon.b_tvalid, mon.a_tvalid};
   assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         empty[i]  = (wr_q[i] == rd_q[i]);
         full[i]   = (wr_q[i][AW-1:0] == rd_q[i][AW-1:0]) && (wr_q[i][AW] != rd_q[i][AW]);
         step[i]   = busy && (w_q[i] <= c_WAIT_MAX);
         tready[i] = busy && step[i] && !full[i];
         push[i]   = tvalid[i] && tready[i];
         head[i]   = mem_q[i][rd_q[i][AW-1:0]];
      end
   end

   assign pop_both = busy && !empty[0] && !empty[1];
   assign heads_eq = (head[0] == head[1]);
`ifdef STREAM_EQ_TLAST_EN
   assign go_drain = (!step[0] && !step[1]) || (pop_both && heads_eq && head[0][FW-1]);
`else
   assign go_drain = !step[0] && !step[1];
`endif

   always_comb begin
      state_d = state_q;
      cycle_d = cycle_q;
      match_d = match_q;
      idx_d   = idx_q;
      mis_d   = mis_q;
      to_d    = to_q;
      for (int i = 0; i < 2; i++) begin
         wr_d[i] = push[i] ? wr_q[i] + PW'(1) : wr_q[i];
         rd_d[i] = pop_both ? rd_q[i] + PW'(1) : rd_q[i];
         if (!complete[i]) begin
            w_d[i] = '0;
         end else if (w_q[i] == c_WAIT_SAT) begin
            w_d[i] = w_q[i];
         end else begin
            w_d[i] = w_q[i] + WW'(1);
         end
      end

      if (pop_both && heads_eq && (match_q != c_CNT_MAX)) begin
         match_d = match_q + CNT_W'(1);
      end

      case (state_q)
         S_RUN: begin
            cycle_d = cycle_q + CNT_W'(1);
            if (pop_both && !heads_eq) begin
               mis_d   = 1'b1;
               idx_d   = match_q;
               state_d = S_FAIL;
            end else if (go_drain) begin
               state_d = S_DRAIN;
            end else if (cycle_q == c_TO_LAST) begin
               to_d    = 1'b1;
               state_d = S_FAIL;
            end
         end
         S_DRAIN: begin
            if (pop_both && !heads_eq) begin
               mis_d   = 1'b1;
               idx_d   = match_q;
               state_d = S_FAIL;
            end else if (empty[0] && empty[1]) begin
               state_d = S_PASS;
            end else if (empty[0] != empty[1]) begin
               // Leftover tokens on one side only: streams differ in length.
               mis_d   = 1'b1;
               idx_d   = match_q;
               state_d = S_FAIL;
            end
         end
         default: begin
            state_d = state_q;
         end
      endcase

      if (mon.start) begin
         state_d = S_RUN;
         cycle_d = '0;
         match_d = '0;
         idx_d   = '0;
         mis_d   = 1'b0;
         to_d    = 1'b0;
         for (int i = 0; i < 2; i++) begin
            wr_d[i] = '0;
            rd_d[i] = '0;
            w_d[i]  = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cycle_q <= '0;
         match_q <= '0;
         idx_q   <= '0;
         mis_q   <= 1'b0;
         to_q    <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            wr_q[i] <= '0;
            rd_q[i] <= '0;
            w_q[i]  <= '0;
         end
      end else begin
         state_q <= state_d;
         cycle_q <= cycle_d;
         match_q <= match_d;
         idx_q   <= idx_d;
         mis_q   <= mis_d;
         to_q    <= to_d;
         for (int i = 0; i < 2; i++) begin
            wr_q[i] <= wr_d[i];
            rd_q[i] <= rd_d[i];
            w_q[i]  <= w_d[i];
         end
      end
   end

   // Storage needs no reset: pointers alone define valid contents.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (push[i]) begin
            mem_q[i][wr_q[i][AW-1:0]] <= tok[i];
         end
      end
   end

   assign mon.a_tready     = tready[0];
   assign mon.b_tready     = tready[1];
   assign mon.a_step       = step[0];
   assign mon.b_step       = step[1];
   assign mon.busy         = busy;
   assign mon.done         = (state_q == S_PASS) || (state_q == S_FAIL);
   assign mon.pass         = (state_q == S_PASS);
   assign mon.mismatch     = mis_q;
   assign mon.timeout      = to_q;
   assign mon.mismatch_idx = idx_q;
   assign mon.match_cnt    = match_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_eq_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_eq_monitor
// Purpose  : Directed scoreboard bench for stream_eq_monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_eq_monitor;

   typedef logic [7:0] tok_arr_t [8];
   typedef struct packed {
      logic        pass;
      logic        mis;
      logic        to;
      logic [15:0] idx;
      logic [15:0] cnt;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   res_t exp_q [$];

   stream_eq_monitor_if #(.DATA_W(8), .CNT_W(16)) ifc ();

   stream_eq_monitor #(
      .DATA_W(8), .DEPTH(4), .WAIT_CYCLES(5), .CNT_W(16), .TIMEOUT(50)
   ) dut (
      .clk (clk),
      .rst (rst),
      .mon (ifc.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {ifc.a_tready, ifc.b_tready, ifc.a_step, ifc.b_step, ifc.busy, ifc.done,
              ifc.pass, ifc.mismatch, ifc.timeout, ifc.mismatch_idx, ifc.match_cnt};
   endfunction

   // Scoreboard monitor: every rising done is matched against the next expected result.
   initial begin
      logic done_prev;
      res_t got, exp;
      done_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (ifc.done && !done_prev) begin
            got = '{ifc.pass, ifc.mismatch, ifc.timeout, ifc.mismatch_idx, ifc.match_cnt};
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 64'(got), 64'h0);
            end else begin
               exp = exp_q.pop_front();
               chk("result{pass,mis,to,idx,cnt}", 64'(got), 64'(exp));
            end
         end
         done_prev = ifc.done;
      end
   end

   task automatic start_run();
      ifc.start = 1'b1;
      tick();
      ifc.start = 1'b0;
      chk("busy_after_start", 64'(ifc.busy), 64'h1);
   endtask

   task automatic send(input bit side, input tok_arr_t d, input int n, input int delay);
      int g;
      repeat (delay) tick();
      for (int i = 0; i < n; i++) begin
         if (side == 1'b0) begin
            ifc.a_tvalid = 1'b1;
            ifc.a_tdata  = d[i];
         end else begin
            ifc.b_tvalid = 1'b1;
            ifc.b_tdata  = d[i];
         end
         g = 0;
         while (((side == 1'b0) ? ifc.a_tready : ifc.b_tready) !== 1'b1 && g < 100) begin
            tick();
            g++;
         end
         if (g == 100) begin
            chk(side ? "b_handshake_timeout" : "a_handshake_timeout", 64'h1, 64'h0);
         end
         tick();
      end
      if (side == 1'b0) ifc.a_tvalid = 1'b0;
      else              ifc.b_tvalid = 1'b0;
   endtask

   task automatic wait_done();
      int g;
      g = 0;
      while (ifc.done !== 1'b1 && g < 300) begin
         tick();
         g++;
      end
      if (g == 300) chk("done_wait_timeout", 64'h1, 64'h0);
      tick();
      ifc.a_complete = 1'b0;
      ifc.b_complete = 1'b0;
      tick();
   endtask

   task automatic complete_both();
      ifc.a_complete = 1'b1;
      ifc.b_complete = 1'b1;
   endtask

   initial begin
      logic all_high;
      ifc.start      = 1'b0;
      ifc.a_complete = 1'b0;
      ifc.b_complete = 1'b0;
      ifc.a_tdata    = '0;
      ifc.b_tdata    = '0;
      ifc.a_tvalid   = 1'b0;
      ifc.b_tvalid   = 1'b0;
`ifdef STREAM_EQ_TLAST_EN
      ifc.a_tlast    = 1'b0;
      ifc.b_tlast    = 1'b0;
`endif
      #1;
      chk("reset_outputs_during_rst", all_outs(), 64'h0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("reset_outputs_after_rst", all_outs(), 64'h0);

      // Identical streams, B skewed four cycles behind A.
      exp_q.push_back('{1'b1, 1'b0, 1'b0, 16'd0, 16'd3});
      start_run();
      fork
         send(1'b0, '{8'h11, 8'h22, 8'h33, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 3, 1);
         send(1'b1, '{8'h11, 8'h22, 8'h33, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 3, 5);
      join
      complete_both();
      wait_done();

      // Data mismatch on the second token.
      exp_q.push_back('{1'b0, 1'b1, 1'b0, 16'd1, 16'd1});
      start_run();
      fork
         send(1'b0, '{8'h11, 8'h22, 8'h33, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 3, 1);
         send(1'b1, '{8'h11, 8'h23, 8'h33, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 3, 5);
      join
      wait_done();

      // Length mismatch: A has one extra token.
      exp_q.push_back('{1'b0, 1'b1, 1'b0, 16'd3, 16'd3});
      start_run();
      fork
         send(1'b0, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0, 8'h0, 8'h0, 8'h0}, 4, 1);
         send(1'b1, '{8'h01, 8'h02, 8'h03, 8'h00, 8'h0, 8'h0, 8'h0, 8'h0}, 3, 5);
      join
      complete_both();
      wait_done();

      // Backpressure: A fills its FIFO while B is silent.
      exp_q.push_back('{1'b1, 1'b0, 1'b0, 16'd0, 16'd6});
      start_run();
      for (int k = 0; k < 4; k++) begin
         ifc.a_tvalid = 1'b1;
         ifc.a_tdata  = 8'hA0 + 8'(k);
         tick();
      end
      chk("a_tready_when_full", 64'(ifc.a_tready), 64'h0);
      fork
         send(1'b0, '{8'hA4, 8'hA5, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 2, 0);
         send(1'b1, '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'h0, 8'h0}, 6, 2);
      join
      complete_both();
      wait_done();

      // Step gating on side A.
      start_run();
      ifc.a_complete = 1'b1;
      repeat (5) tick();
      chk("a_step_5_after_complete", 64'(ifc.a_step), 64'h1);
      tick();
      chk("a_step_6_after_complete", 64'(ifc.a_step), 64'h0);
      chk("b_step_unaffected", 64'(ifc.b_step), 64'h1);
      ifc.a_complete = 1'b0;
      tick();
      chk("a_step_after_complete_drop", 64'(ifc.a_step), 64'h1);
      ifc.a_complete = 1'b1;
      repeat (3) tick();
      ifc.a_complete = 1'b0;
      all_high = 1'b1;
      for (int k = 0; k < 8; k++) begin
         all_high = all_high & ifc.a_step;
         tick();
      end
      chk("a_step_high_after_pulse", 64'(all_high), 64'h1);

      // Timeout: restart from RUN, nobody completes.
      exp_q.push_back('{1'b0, 1'b0, 1'b1, 16'd0, 16'd0});
      start_run();
      repeat (49) tick();
      chk("done_before_timeout", 64'(ifc.done), 64'h0);
      tick();
      chk("done_at_timeout", 64'(ifc.done), 64'h1);
      chk("timeout_flag", 64'(ifc.timeout), 64'h1);
      tick();

      // Asynchronous reset in the middle of a run with matches accumulated.
      start_run();
      fork
         send(1'b0, '{8'h5A, 8'h6B, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 2, 0);
         send(1'b1, '{8'h5A, 8'h6B, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0}, 2, 0);
      join
      tick();
      chk("match_cnt_before_rst", 64'(ifc.match_cnt), 64'h2);
      #2;
      rst = 1'b1;
      #1;
      chk("outputs_async_rst", all_outs(), 64'h0);
      tick();
      rst = 1'b0;
      tick();
      chk("outputs_after_mid_run_rst", all_outs(), 64'h0);

      chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
